// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned MIN_DIV   = 4;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO with registered head, count and flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] dout_nxt;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_ok     = pop & ~empty;
    push_ok    = push & (~full | pop_ok);
    rd_ptr_inc = rd_ptr + AW'(1);
    count_nxt  = count + CW'(push_ok) - CW'(pop_ok);
    dout_nxt   = dout;
    if (pop_ok) begin
      if (count > CW'(1)) begin
        dout_nxt = mem[rd_ptr_inc];
      end else if (push_ok) begin
        dout_nxt = din;
      end
    end else if (empty && push_ok) begin
      dout_nxt = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      dout  <= dout_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with ce-gated bit timing, byte FIFO and sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        ce,
  input  logic [DIV_W-1:0]            divisor,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ferr,
  output logic                        ovr,
  input  logic                        err_clr,
  output logic                        busy
);

  localparam int unsigned BIDX_W = $clog2(DATA_BITS);

  logic                 rx_meta;
  logic                 rxs;
  rx_state_t            state_q;
  rx_state_t            state_nxt;
  logic [DIV_W-1:0]     cnt_q;
  logic [DIV_W-1:0]     cnt_nxt;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_nxt;
  logic [DIV_W-1:0]     div_sel;
  logic [BIDX_W-1:0]    bidx_q;
  logic [BIDX_W-1:0]    bidx_nxt;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 busy_nxt;
  logic                 push_c;
  logic                 ferr_set_c;
  logic                 ovr_set_c;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchronizer, idle-high so reset never looks like a start edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(MIN_DIV);
      bidx_q  <= '0;
      shift_q <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      div_q   <= div_nxt;
      bidx_q  <= bidx_nxt;
      shift_q <= shift_nxt;
      busy    <= busy_nxt;
    end
  end

  // Frame deserializer; all timing advances on ce cycles only.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    div_nxt    = div_q;
    bidx_nxt   = bidx_q;
    shift_nxt  = shift_q;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    div_sel    = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            div_nxt   = div_sel;
            cnt_nxt   = div_sel >> 1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rxs) begin
              state_nxt = DATA;
              cnt_nxt   = div_q - DIV_W'(1);
              bidx_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt_q - DIV_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_nxt = {rxs, shift_q[DATA_BITS-1:1]};
            cnt_nxt   = div_q - DIV_W'(1);
            if (bidx_q == BIDX_W'(DATA_BITS - 1)) begin
              state_nxt = STOP;
            end else begin
              bidx_nxt = bidx_q + BIDX_W'(1);
            end
          end else begin
            cnt_nxt = cnt_q - DIV_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (rxs) begin
              push_c    = 1'b1;
              state_nxt = IDLE;
            end else begin
              ferr_set_c = 1'b1;
              state_nxt  = BREAK;
            end
          end else begin
            cnt_nxt = cnt_q - DIV_W'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt != IDLE);
  end

  assign ovr_set_c = push_c & fifo_full & ~rx_ready;

  // Sticky flags; a new event outranks a coincident clear.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      ferr <= ferr_set_c | (ferr & ~err_clr);
      ovr  <= ovr_set_c | (ovr & ~err_clr);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push_c),
    .pop   (rx_ready),
    .din   (shift_nxt),
    .dout  (rx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with ce ticks of three clk_sys cycles.
module tb_uart_rx_fifo;

  logic        clk_sys;
  logic        reset;
  logic        ce;
  logic [15:0] divisor;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  fifo_count;
  logic        ferr;
  logic        ovr;
  logic        err_clr;
  logic        busy;

  int n_cmp;
  int n_err;

  uart_rx_fifo #(
    .FIFO_DEPTH (16),
    .DIV_W      (16)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .divisor    (divisor),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .ferr       (ferr),
    .ovr        (ovr),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // One ce tick: ce high for the first clk_sys edge, low for the next two.
  task automatic tick(input logic pop, input logic clr);
    ce = 1'b1; rx_ready = pop; err_clr = clr;
    @(negedge clk_sys);
    ce = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  // Drives start, 8 data bits LSB first and stop; reports the first tick ending with rx_valid.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ticks,
                            input logic [15:0] div_mid, input int pop_t, input int clr_t,
                            output int first_valid);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    first_valid = -1;
    for (int t = 0; t < 10 * bit_ticks; t++) begin
      rx = fr[t / bit_ticks];
      if (t == 2 * bit_ticks) divisor = div_mid;
      tick(t == pop_t, t == clr_t);
      if (first_valid < 0 && rx_valid) first_valid = t;
    end
  endtask

  task automatic pop_byte();
    rx_ready = 1'b1;
    @(negedge clk_sys);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ce = 1'b0; rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0; divisor = 16'd8;
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_cmp++; if ({ferr, ovr, busy} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {ferr, ovr, busy}); end
    reset = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic test_single_byte();
    int fv;
    send_frame(8'hA5, 1'b1, 8, 16'd20, -1, -1, fv);
    divisor = 16'd8;
    n_cmp++; if (fv !== 78) begin n_err++; $display("FAIL a5_latency got tick %0d want 78", fv); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL a5_valid got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL a5_data got %h want a5", rx_data); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL a5_count got %0d want 1", fifo_count); end
    n_cmp++; if ({ferr, busy} !== 2'b00) begin n_err++; $display("FAIL a5_ferr_busy got %b want 00", {ferr, busy}); end
    pop_byte();
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL a5_pop_valid got %b want 0", rx_valid); end
  endtask

  task automatic test_glitch();
    for (int t = 0; t < 9; t++) begin
      rx = (t < 3) ? 1'b0 : 1'b1;
      tick(1'b0, 1'b0);
      if (t == 2) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_hi got %b want 1", busy); end
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_lo got %b want 0", busy); end
    n_cmp++; if ({rx_valid, ferr, ovr} !== 3'b000) begin n_err++; $display("FAIL glitch_no_byte got %b want 000", {rx_valid, ferr, ovr}); end
  endtask

  task automatic test_break();
    int fv;
    send_frame(8'h3C, 1'b0, 8, 16'd8, -1, 78, fv);
    n_cmp++; if (ferr !== 1'b1) begin n_err++; $display("FAIL brk_set_beats_clr got %b want 1", ferr); end
    repeat (40) tick(1'b0, 1'b0);
    n_cmp++; if ({ferr, busy} !== 2'b11) begin n_err++; $display("FAIL brk_hold got %b want 11", {ferr, busy}); end
    n_cmp++; if (fifo_count !== 5'd0) begin n_err++; $display("FAIL brk_count got %0d want 0", fifo_count); end
    rx = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL brk_exit got %b want 0", busy); end
    send_frame(8'h55, 1'b1, 8, 16'd8, -1, -1, fv);
    n_cmp++; if (rx_data !== 8'h55) begin n_err++; $display("FAIL brk_next_data got %h want 55", rx_data); end
    n_cmp++; if ({fifo_count, ferr} !== {5'd1, 1'b1}) begin n_err++; $display("FAIL brk_next_cnt_ferr got %0d/%b want 1/1", fifo_count, ferr); end
    pop_byte();
  endtask

  task automatic test_err_clr();
    clear_errors();
    n_cmp++; if ({ferr, ovr} !== 2'b00) begin n_err++; $display("FAIL err_clr got %b want 00", {ferr, ovr}); end
  endtask

  task automatic test_overrun();
    int fv;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 8, 16'd8, -1, -1, fv);
    n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL ovr_count got %0d want 16", fifo_count); end
    n_cmp++; if (ovr !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", ovr); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rx_data !== 8'(i)) begin n_err++; $display("FAIL ovr_pop%0d got %h want %h", i, rx_data, 8'(i)); end
      pop_byte();
    end
    n_cmp++; if ({rx_valid, fifo_count} !== 6'd0) begin n_err++; $display("FAIL ovr_drained got %b/%0d want 0/0", rx_valid, fifo_count); end
    clear_errors();
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL ovr_clr got %b want 0", ovr); end
  endtask

  task automatic test_full_pop();
    int fv;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 8, 16'd8, -1, -1, fv);
    send_frame(8'h10, 1'b1, 8, 16'd8, 78, -1, fv);
    n_cmp++; if (fifo_count !== 5'd16) begin n_err++; $display("FAIL fullpop_count got %0d want 16", fifo_count); end
    n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL fullpop_ovr got %b want 0", ovr); end
    for (int i = 1; i <= 16; i++) begin
      n_cmp++; if (rx_data !== 8'(i)) begin n_err++; $display("FAIL fullpop_pop%0d got %h want %h", i, rx_data, 8'(i)); end
      pop_byte();
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_clamp_reset();
    int fv;
    divisor = 16'd2;
    send_frame(8'h96, 1'b1, 4, 16'd2, -1, -1, fv);
    n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL clamp_early got %b want 0", rx_valid); end
    tick(1'b0, 1'b0);
    n_cmp++; if (rx_data !== 8'h96) begin n_err++; $display("FAIL clamp_data got %h want 96", rx_data); end
    n_cmp++; if (fifo_count !== 5'd1) begin n_err++; $display("FAIL clamp_count got %0d want 1", fifo_count); end
    send_frame(8'h00, 1'b0, 4, 16'd2, -1, -1, fv);
    rx = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    n_cmp++; if ({ferr, busy, fifo_count} !== {1'b1, 1'b0, 5'd1}) begin n_err++; $display("FAIL clamp_ferr got %b/%b/%0d want 1/0/1", ferr, busy, fifo_count); end
    for (int t = 0; t < 10; t++) begin
      rx = (t < 4) ? 1'b0 : 1'b1;
      tick(1'b0, 1'b0);
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_data_busy got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if ({rx_valid, busy, ferr, ovr} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b want 0000", {rx_valid, busy, ferr, ovr}); end
    n_cmp++; if ({fifo_count, rx_data} !== 13'd0) begin n_err++; $display("FAIL rst_mid_fifo got %0d/%h want 0/00", fifo_count, rx_data); end
    reset = 1'b0;
    rx = 1'b1;
    repeat (3) tick(1'b0, 1'b0);
    n_cmp++; if ({busy, rx_valid} !== 2'b00) begin n_err++; $display("FAIL rst_after got %b want 00", {busy, rx_valid}); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_break();
    test_err_clr();
    test_overrun();
    test_full_pop();
    test_clamp_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
